// File: rtl/int8_mac_accumulator_pkg.sv
// ----------------------------------------------------------------------------
// mac_acc_pkg
// Shared types and constants for the int8 multiply-accumulate stage.
//   act_t / wgt_t : signed 8-bit activation and weight
//   diff_t        : signed 9-bit zero-point-corrected activation
//   prod_t        : signed 18-bit product (9-bit x 8-bit)
//   acc_t         : signed 32-bit accumulator / bias / result
//   len_t         : unsigned dot-product length field
//   state_t       : control FSM states
// ----------------------------------------------------------------------------
package mac_acc_pkg;

   localparam int IN_RESOLUTION   = 8;
   localparam int ACC_RESOLUTION  = 32;
   localparam int LEN_WIDTH       = 10;
   localparam int DIFF_RESOLUTION = IN_RESOLUTION + 1;
   localparam int PROD_RESOLUTION = DIFF_RESOLUTION + IN_RESOLUTION + 1;

   typedef logic signed [IN_RESOLUTION-1:0]   act_t;
   typedef logic signed [IN_RESOLUTION-1:0]   wgt_t;
   typedef logic signed [DIFF_RESOLUTION-1:0] diff_t;
   typedef logic signed [PROD_RESOLUTION-1:0] prod_t;
   typedef logic signed [ACC_RESOLUTION-1:0]  acc_t;
   typedef logic        [LEN_WIDTH-1:0]       len_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   localparam acc_t ACC_MAX = 32'h7FFF_FFFF;
   localparam acc_t ACC_MIN = 32'h8000_0000;

endpackage

// File: rtl/int8_mac_accumulator_if.sv
// ----------------------------------------------------------------------------
// int8_mac_accumulator_if
// Bundles the two streams of the MAC stage.
//   mac_* : input beats (activation/weight pairs), valid/ready handshake
//   acc_* : int32 dot-product results, valid/ready handshake, sticky sat flag
// Modports:
//   slave  : the accumulator itself (consumes beats, produces results)
//   master : whatever feeds beats in and takes results out
// ----------------------------------------------------------------------------
interface int8_mac_accumulator_if;
   import mac_acc_pkg::*;

   logic mac_valid_i;
   logic mac_ready_o;
   act_t mac_act_i;
   wgt_t mac_wgt_i;
   logic acc_valid_o;
   logic acc_ready_i;
   acc_t acc_data_o;
   logic acc_sat_o;

   modport slave (
      input  mac_valid_i, mac_act_i, mac_wgt_i, acc_ready_i,
      output mac_ready_o, acc_valid_o, acc_data_o, acc_sat_o
   );

   modport master (
      output mac_valid_i, mac_act_i, mac_wgt_i, acc_ready_i,
      input  mac_ready_o, acc_valid_o, acc_data_o, acc_sat_o
   );

endinterface

// File: rtl/int8_mac_accumulator_sat_add.sv
// ----------------------------------------------------------------------------
// sat_add
// Combinational signed saturating adder: 32-bit accumulator plus 18-bit
// product. The sum is formed in 33 bits and clamped to the int32 range.
//   a_i   : signed 32-bit addend
//   b_i   : signed 18-bit addend
//   sum_o : clamped signed 32-bit result
//   ovf_o : high when clamping occurred
// ----------------------------------------------------------------------------
module sat_add
   import mac_acc_pkg::*;
(
   input  acc_t  a_i,
   input  prod_t b_i,
   output acc_t  sum_o,
   output logic  ovf_o
);

   logic [ACC_RESOLUTION:0] wide_sum;

   // The two top bits of the 33-bit sum disagree exactly when the true
   // result has left the int32 range; 01 means too big, 10 too small.
   always_comb begin
      wide_sum = {a_i[ACC_RESOLUTION-1], a_i}
               + {{(ACC_RESOLUTION + 1 - PROD_RESOLUTION){b_i[PROD_RESOLUTION-1]}}, b_i};
      sum_o    = wide_sum[ACC_RESOLUTION-1:0];
      ovf_o    = 1'b0;
      if (wide_sum[ACC_RESOLUTION:ACC_RESOLUTION-1] == 2'b01) begin
         sum_o = ACC_MAX;
         ovf_o = 1'b1;
      end else if (wide_sum[ACC_RESOLUTION:ACC_RESOLUTION-1] == 2'b10) begin
         sum_o = ACC_MIN;
         ovf_o = 1'b1;
      end
   end

endmodule

// File: rtl/int8_mac_accumulator.sv
// ----------------------------------------------------------------------------
// int8_mac_accumulator
// Accumulates (act - act_zp) * wgt over cfg_len_i beats onto an int32 bias
// with saturation, then offers the result downstream.
//   clk_i        : clock, all state on rising edge
//   rst_i        : asynchronous active-high reset
//   cfg_len_i    : products per dot product (0 behaves as 1)
//   cfg_bias_i   : signed int32 starting value of the accumulator
//   cfg_act_zp_i : signed activation zero-point
//   bus          : slave side of the mac_*/acc_* streams
// Configuration is captured on the first beat of each dot product only.
// ----------------------------------------------------------------------------
module int8_mac_accumulator
   import mac_acc_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  len_t                   cfg_len_i,
   input  acc_t                   cfg_bias_i,
   input  act_t                   cfg_act_zp_i,
   int8_mac_accumulator_if.slave  bus
);

   state_t state_q, state_d;
   acc_t   acc_q,   acc_d;
   logic   sat_q,   sat_d;
   len_t   cnt_q,   cnt_d;
   len_t   len_q,   len_d;
   act_t   zp_q,    zp_d;

   logic   mac_ready;
   logic   acc_valid;
   logic   beat;
   act_t   zp_sel;
   acc_t   add_base;
   diff_t  diff;
   prod_t  prod;
   acc_t   sum;
   logic   ovf;

   // The first beat of a dot product uses the live configuration; later
   // beats use the captured zero-point and the running accumulator.
   always_comb begin
      zp_sel   = (state_q == S_IDLE) ? cfg_act_zp_i : zp_q;
      add_base = (state_q == S_IDLE) ? cfg_bias_i   : acc_q;
      diff     = diff_t'(bus.mac_act_i) - diff_t'(zp_sel);
      prod     = prod_t'(diff) * prod_t'(bus.mac_wgt_i);
   end

   sat_add u_sat_add (
      .a_i   (add_base),
      .b_i   (prod),
      .sum_o (sum),
      .ovf_o (ovf)
   );

   assign beat = bus.mac_valid_i && mac_ready;

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         sat_q   <= 1'b0;
         cnt_q   <= '0;
         len_q   <= '0;
         zp_q    <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         sat_q   <= sat_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         zp_q    <= zp_d;
      end
   end

   // Next-state and datapath update. cnt counts beats already absorbed,
   // so the beat arriving with cnt == len-1 is the last one.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      sat_d   = sat_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      zp_d    = zp_q;
      unique case (state_q)
         S_IDLE: begin
            if (beat) begin
               len_d   = (cfg_len_i == '0) ? len_t'(1) : cfg_len_i;
               zp_d    = cfg_act_zp_i;
               acc_d   = sum;
               sat_d   = ovf;
               cnt_d   = len_t'(1);
               state_d = (len_d == len_t'(1)) ? S_OUT : S_ACC;
            end
         end
         S_ACC: begin
            if (beat) begin
               acc_d = sum;
               sat_d = sat_q | ovf;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == len_q - 1'b1) begin
                  state_d = S_OUT;
               end
            end
         end
         S_OUT: begin
            if (bus.acc_ready_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs depend on registered state only (plus reset gating of ready),
   // so there is no combinational path from acc_ready_i to mac_ready_o.
   always_comb begin
      mac_ready = 1'b0;
      acc_valid = 1'b0;
      unique case (state_q)
         S_IDLE:  mac_ready = !rst_i;
         S_ACC:   mac_ready = !rst_i;
         S_OUT:   acc_valid = 1'b1;
         default: mac_ready = 1'b0;
      endcase
   end

   assign bus.mac_ready_o = mac_ready;
   assign bus.acc_valid_o = acc_valid;
   assign bus.acc_data_o  = acc_q;
   assign bus.acc_sat_o   = sat_q;

endmodule

// File: tb/tb_int8_mac_accumulator.sv
// ----------------------------------------------------------------------------
// tb_int8_mac_accumulator
// Drives directed and random dot products into int8_mac_accumulator and
// compares each result against an arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_int8_mac_accumulator;
   import mac_acc_pkg::*;

   localparam longint MAXV = 64'sd2147483647;
   localparam longint MINV = -64'sd2147483648;

   logic clk = 1'b0;
   logic rst;
   len_t cfg_len;
   acc_t cfg_bias;
   act_t cfg_zp;

   int8_mac_accumulator_if bus();

   int8_mac_accumulator dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .cfg_len_i    (cfg_len),
      .cfg_bias_i   (cfg_bias),
      .cfg_act_zp_i (cfg_zp),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   int checkCount = 0;
   int failCount  = 0;
   int beatAct[16];
   int beatWgt[16];

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Reference: plain integer accumulation, clamped after every product.
   function automatic void refDot(input int n, input longint bias, input longint zp,
                                  output longint res, output longint sat);
      res = bias;
      sat = 0;
      for (int i = 0; i < n; i++) begin
         res = res + (longint'(beatAct[i]) - zp) * longint'(beatWgt[i]);
         if (res > MAXV) begin
            res = MAXV;
            sat = 1;
         end else if (res < MINV) begin
            res = MINV;
            sat = 1;
         end
      end
   endfunction

   // Presents one beat at a falling edge and holds it through one accept.
   task automatic sendBeat(input int act, input int wgt);
      int waitCount = 0;
      @(negedge clk);
      while (!bus.mac_ready_o && waitCount < 50) begin
         @(negedge clk);
         waitCount++;
      end
      if (!bus.mac_ready_o) checkOutput("mac_ready timeout", 0, 1);
      bus.mac_valid_i = 1'b1;
      bus.mac_act_i   = act_t'(act);
      bus.mac_wgt_i   = wgt_t'(wgt);
      @(posedge clk);
      #1;
      bus.mac_valid_i = 1'b0;
   endtask

   // Runs one full dot product from beatAct/beatWgt, scrambling cfg after
   // the first beat, then checks latency, result, backpressure and bubble.
   task automatic applyStimulus(input string tag, input int len, input longint bias,
                                input longint zp, input int gap, input int stall);
      int n;
      longint expData;
      longint expSat;
      n = (len == 0) ? 1 : len;
      refDot(n, bias, zp, expData, expSat);
      cfg_len  = len_t'(len);
      cfg_bias = acc_t'(bias);
      cfg_zp   = act_t'(zp);
      for (int i = 0; i < n; i++) begin
         sendBeat(beatAct[i], beatWgt[i]);
         cfg_len  = len_t'($urandom);
         cfg_bias = acc_t'($urandom);
         cfg_zp   = act_t'($urandom);
         if (i < n - 1) begin
            checkOutput({tag, " early valid"}, longint'(bus.acc_valid_o), 0);
            repeat (gap) @(posedge clk);
         end
      end
      checkOutput({tag, " valid latency"}, longint'(bus.acc_valid_o), 1);
      checkOutput({tag, " data"}, longint'(bus.acc_data_o), expData);
      checkOutput({tag, " sat"}, longint'(bus.acc_sat_o), expSat);
      checkOutput({tag, " ready while out"}, longint'(bus.mac_ready_o), 0);
      for (int s = 0; s < stall; s++) begin
         @(posedge clk);
         #1;
         checkOutput({tag, " held valid"}, longint'(bus.acc_valid_o), 1);
         checkOutput({tag, " held data"}, longint'(bus.acc_data_o), expData);
         checkOutput({tag, " held ready"}, longint'(bus.mac_ready_o), 0);
      end
      @(negedge clk);
      bus.acc_ready_i = 1'b1;
      @(posedge clk);
      #1;
      bus.acc_ready_i = 1'b0;
      checkOutput({tag, " valid drop"}, longint'(bus.acc_valid_o), 0);
      checkOutput({tag, " ready rise"}, longint'(bus.mac_ready_o), 1);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int len;
      int mode;
      longint bias;
      rst             = 1'b1;
      cfg_len         = '0;
      cfg_bias        = '0;
      cfg_zp          = '0;
      bus.mac_valid_i = 1'b0;
      bus.mac_act_i   = '0;
      bus.mac_wgt_i   = '0;
      bus.acc_ready_i = 1'b0;
      #1;
      checkOutput("reset data", longint'(bus.acc_data_o), 0);
      checkOutput("reset valid", longint'(bus.acc_valid_o), 0);
      checkOutput("reset sat", longint'(bus.acc_sat_o), 0);
      checkOutput("reset ready", longint'(bus.mac_ready_o), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("ready after reset", longint'(bus.mac_ready_o), 1);

      // Basic dot product.
      beatAct[0] = 2; beatWgt[0] = 5;
      beatAct[1] = 3; beatWgt[1] = -6;
      beatAct[2] = 4; beatWgt[2] = 7;
      applyStimulus("basic", 3, 100, 0, 0, 0);

      // Zero-point with extreme operands.
      beatAct[0] = -128; beatWgt[0] = -128;
      applyStimulus("zp extremes", 1, 0, 127, 0, 0);

      // Positive saturation, then a clean follow-up clears the flag.
      beatAct[0] = 127; beatWgt[0] = 127;
      beatAct[1] = 127; beatWgt[1] = 127;
      applyStimulus("pos sat", 2, 64'sh7FFF_FF00, 0, 0, 0);
      beatAct[0] = 1; beatWgt[0] = 1;
      applyStimulus("after sat", 1, 0, 0, 0, 0);

      // Negative saturation.
      beatAct[0] = 127; beatWgt[0] = -128;
      applyStimulus("neg sat", 1, MINV + 100, -128, 0, 0);

      // Backpressure.
      beatAct[0] = 10; beatWgt[0] = 10;
      beatAct[1] = -7; beatWgt[1] = 3;
      applyStimulus("backpressure", 2, 50, 1, 0, 5);

      // len 0 behaves as len 1.
      beatAct[0] = 1; beatWgt[0] = 2;
      applyStimulus("len0", 0, -5, 0, 0, 0);

      // Same four-beat sum with and without input gaps.
      for (int i = 0; i < 4; i++) begin
         beatAct[i] = 11 * i - 20;
         beatWgt[i] = 37 - 9 * i;
      end
      applyStimulus("no gap", 4, 1234, 3, 0, 0);
      applyStimulus("gapped", 4, 1234, 3, 3, 0);

      // Reset mid-operation discards the partial sum.
      cfg_len  = len_t'(4);
      cfg_bias = acc_t'(1000);
      cfg_zp   = '0;
      sendBeat(5, 5);
      sendBeat(3, 3);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("midreset data", longint'(bus.acc_data_o), 0);
      checkOutput("midreset valid", longint'(bus.acc_valid_o), 0);
      checkOutput("midreset ready", longint'(bus.mac_ready_o), 0);
      @(negedge clk);
      rst = 1'b0;
      beatAct[0] = 0; beatWgt[0] = 9;
      applyStimulus("after reset", 1, 7, 0, 0, 0);

      // Random dot products, biased toward the saturation boundaries.
      for (int t = 0; t < 25; t++) begin
         len  = $urandom_range(0, 6);
         mode = $urandom_range(0, 2);
         if (mode == 0)      bias = longint'(int'($urandom));
         else if (mode == 1) bias = MAXV - longint'($urandom_range(0, 40000));
         else                bias = MINV + longint'($urandom_range(0, 40000));
         for (int i = 0; i < 6; i++) begin
            beatAct[i] = int'($urandom_range(0, 255)) - 128;
            beatWgt[i] = int'($urandom_range(0, 255)) - 128;
         end
         applyStimulus("random", len, bias, longint'(int'($urandom_range(0, 255)) - 128),
                       $urandom_range(0, 2), $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
